// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad front end: rotates an active-low column drive, synchronises and
// debounces the rows, and reports one key code per physical press.
module keypad_scan_debounce #(
  parameter int SCAN_DIV  = 4,
  parameter int DB_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] row_in,
  output logic [3:0] scan,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] dbg_state
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DB_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_DONE  = DB_W'(DB_CYCLES);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DB_W-1:0]   db_q, db_d, db_inc;
  logic [1:0]        col_q, col_d;
  logic [3:0]        pat_q, pat_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [3:0]        code_q, code_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;
  logic [3:0]        sync1_q, row_s_q;
  logic              one_zero;
  logic [1:0]        zero_idx;

  // Rows are asynchronous to CLK; nothing downstream looks at row_in directly.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 4'hF;
      row_s_q <= 4'hF;
    end else begin
      sync1_q <= row_in;
      row_s_q <= sync1_q;
    end
  end

  // A press is only trusted when exactly one row is pulled low.
  always_comb begin
    one_zero = 1'b0;
    zero_idx = 2'd0;
    case (row_s_q)
      4'b1110: begin one_zero = 1'b1; zero_idx = 2'd0; end
      4'b1101: begin one_zero = 1'b1; zero_idx = 2'd1; end
      4'b1011: begin one_zero = 1'b1; zero_idx = 2'd2; end
      4'b0111: begin one_zero = 1'b1; zero_idx = 2'd3; end
      default: begin one_zero = 1'b0; zero_idx = 2'd0; end
    endcase
  end

  assign db_inc = db_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    db_d      = db_q;
    col_d     = col_q;
    pat_d     = pat_q;
    row_idx_d = row_idx_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    case (state_q)
      ST_SCAN: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else if (one_zero) begin
          pat_d     = row_s_q;
          row_idx_d = zero_idx;
          db_d      = DB_W'(1);
          state_d   = ST_DEBOUNCE;
        end else begin
          col_d = col_q + 2'd1;
          div_d = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (row_s_q == pat_q) begin
          if (db_inc == DB_DONE) begin
            valid_d = 1'b1;
            code_d  = {col_q, row_idx_q};
            held_d  = 1'b1;
            db_d    = '0;
            state_d = ST_HELD;
          end else begin
            db_d = db_inc;
          end
        end else begin
          // Bounce: give up on this press and resume the same column.
          div_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_HELD: begin
        if (row_s_q == 4'hF) begin
          if (db_inc == DB_DONE) begin
            held_d  = 1'b0;
            db_d    = '0;
            div_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = ST_SCAN;
          end else begin
            db_d = db_inc;
          end
        end else begin
          db_d = '0;
        end
      end
      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_SCAN;
      div_q     <= '0;
      db_q      <= '0;
      col_q     <= 2'd0;
      pat_q     <= 4'hF;
      row_idx_q <= 2'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      db_q      <= db_d;
      col_q     <= col_d;
      pat_q     <= pat_d;
      row_idx_q <= row_idx_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  // key_valid is a single-cycle strobe with no back-pressure: the consumer
  // must take key_code in the cycle key_valid is high.
  assign scan      = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign dbg_state = state_q;

endmodule
